// File: rtl/sat_pkg.sv
// -----------------------------------------------------------------------------
// sat_pkg
// Shared types and defaults for the WalkSAT pick pipeline.
// Revision: 1.0
// -----------------------------------------------------------------------------
`default_nettype none

package sat_pkg;

  // Default configuration shared with the neighbouring pipeline stages
  localparam int DEF_NUM_LITERALS     = 3;
  localparam int DEF_NUM_CLAUSES_BITS = 5;
  localparam int DEF_VAR_BITS         = 8;
  localparam int DEF_RAND_BITS        = 8;

  // Slot index width; never narrower than one bit
  function automatic int cand_idx_bits(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int CAND_IDX_BITS = cand_idx_bits(DEF_NUM_LITERALS);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DECIDE  = 2'd2,
    OUTPUT  = 2'd3
  } state_t;

  // One candidate record at the default widths
  typedef struct packed {
    logic [DEF_VAR_BITS-1:0]         var_idx;
    logic [DEF_NUM_CLAUSES_BITS-1:0] brk;
  } cand_t;

endpackage

`default_nettype wire

// File: rtl/candidate_buffer.sv
// -----------------------------------------------------------------------------
// candidate_buffer
// Register array holding the candidates of one clause; one write port,
// one combinational read port.
// Revision: 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module candidate_buffer
  import sat_pkg::*;
#(
  parameter int NUM_LITERALS     = DEF_NUM_LITERALS,
  parameter int NUM_CLAUSES_BITS = DEF_NUM_CLAUSES_BITS,
  parameter int VAR_BITS         = DEF_VAR_BITS,
  parameter int IDX_BITS         = cand_idx_bits(NUM_LITERALS)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        clear,
  input  logic                        wr_en,
  input  logic [IDX_BITS-1:0]         wr_slot,
  input  logic [VAR_BITS-1:0]         wr_var,
  input  logic [NUM_CLAUSES_BITS-1:0] wr_break,
  input  logic [IDX_BITS-1:0]         rd_idx,
  output logic [VAR_BITS-1:0]         rd_var,
  output logic [NUM_CLAUSES_BITS-1:0] rd_break
);

  logic [VAR_BITS-1:0]         r_var   [NUM_LITERALS];
  logic [NUM_CLAUSES_BITS-1:0] r_break [NUM_LITERALS];

  // Slot storage: cleared on reset or abort, otherwise written per accepted beat
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_LITERALS; i++) begin
        r_var[i]   <= '0;
        r_break[i] <= '0;
      end
    end else if (clear) begin
      for (int i = 0; i < NUM_LITERALS; i++) begin
        r_var[i]   <= '0;
        r_break[i] <= '0;
      end
    end else if (wr_en) begin
      r_var[wr_slot]   <= wr_var;
      r_break[wr_slot] <= wr_break;
    end
  end

  // Read mux; the selector only ever presents an index of a written slot
  assign rd_var   = r_var[rd_idx];
  assign rd_break = r_break[rd_idx];

endmodule

`default_nettype wire

// File: rtl/flip_candidate_selector.sv
// -----------------------------------------------------------------------------
// flip_candidate_selector
// WalkSAT pick stage: collects the candidates of one unsatisfied clause and
// selects a freebie, a noise-driven random pick or the greedy minimum.
// Revision: 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module flip_candidate_selector
  import sat_pkg::*;
#(
  parameter int NUM_LITERALS     = DEF_NUM_LITERALS,
  parameter int NUM_CLAUSES_BITS = DEF_NUM_CLAUSES_BITS,
  parameter int VAR_BITS         = DEF_VAR_BITS,
  parameter int RAND_BITS        = DEF_RAND_BITS
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        abort_i,
  input  logic                        start_i,
  input  logic [RAND_BITS-1:0]        noise_thresh_i,
  input  logic [RAND_BITS-1:0]        rand_i,
  input  logic                        cand_valid_i,
  output logic                        cand_ready_o,
  input  logic [VAR_BITS-1:0]         cand_var_i,
  input  logic [NUM_CLAUSES_BITS-1:0] cand_break_i,
  input  logic                        cand_last_i,
  output logic                        sel_valid_o,
  input  logic                        sel_ready_i,
  output logic [VAR_BITS-1:0]         sel_var_o,
  output logic [NUM_CLAUSES_BITS-1:0] sel_break_o,
  output logic                        sel_greedy_o,
  output logic                        busy_o
);

  localparam int IDX_BITS = cand_idx_bits(NUM_LITERALS);
  localparam int CNT_BITS = $clog2(NUM_LITERALS + 1);

  state_t                      r_state;
  logic [CNT_BITS-1:0]         r_count;
  logic [NUM_CLAUSES_BITS-1:0] r_min_break;
  logic [IDX_BITS-1:0]         r_min_idx;
  logic [RAND_BITS-1:0]        r_thresh;
  logic [RAND_BITS-1:0]        r_rand_a;
  logic [VAR_BITS-1:0]         r_sel_var;
  logic [NUM_CLAUSES_BITS-1:0] r_sel_break;
  logic                        r_sel_greedy;

  logic                        w_beat;
  logic                        w_final;
  logic                        w_noise;
  logic [31:0]                 w_rand_mod;
  logic [IDX_BITS-1:0]         w_sel_idx;
  logic [VAR_BITS-1:0]         w_rd_var;
  logic [NUM_CLAUSES_BITS-1:0] w_rd_break;

  assign w_beat  = (r_state == COLLECT) && cand_valid_i;
  assign w_final = cand_last_i || (r_count == CNT_BITS'(NUM_LITERALS - 1));

  // Noise only applies when no zero-break freebie exists; count is >= 1 in DECIDE
  assign w_noise    = (r_rand_a < r_thresh) && (r_min_break != '0);
  assign w_rand_mod = 32'(rand_i) % ((r_count == '0) ? 32'd1 : 32'(r_count));
  assign w_sel_idx  = w_noise ? w_rand_mod[IDX_BITS-1:0] : r_min_idx;

  candidate_buffer #(
    .NUM_LITERALS     (NUM_LITERALS),
    .NUM_CLAUSES_BITS (NUM_CLAUSES_BITS),
    .VAR_BITS         (VAR_BITS),
    .IDX_BITS         (IDX_BITS)
  ) u_buffer (
    .clk      (clk),
    .reset    (reset),
    .clear    (abort_i),
    .wr_en    (w_beat),
    .wr_slot  (r_count[IDX_BITS-1:0]),
    .wr_var   (cand_var_i),
    .wr_break (cand_break_i),
    .rd_idx   (w_sel_idx),
    .rd_var   (w_rd_var),
    .rd_break (w_rd_break)
  );

  // Control FSM with running minimum and registered selection
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_count      <= '0;
      r_min_break  <= '0;
      r_min_idx    <= '0;
      r_thresh     <= '0;
      r_rand_a     <= '0;
      r_sel_var    <= '0;
      r_sel_break  <= '0;
      r_sel_greedy <= 1'b0;
    end else if (abort_i) begin
      r_state      <= IDLE;
      r_count      <= '0;
      r_min_break  <= '0;
      r_min_idx    <= '0;
      r_sel_var    <= '0;
      r_sel_break  <= '0;
      r_sel_greedy <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_count     <= '0;
          r_min_break <= '0;
          r_min_idx   <= '0;
          if (start_i) begin
            r_thresh <= noise_thresh_i;
            r_rand_a <= rand_i;
            r_state  <= COLLECT;
          end
        end
        COLLECT: begin
          if (cand_valid_i) begin
            r_count <= r_count + CNT_BITS'(1);
            // Strict compare keeps the lowest slot on ties
            if ((r_count == '0) || (cand_break_i < r_min_break)) begin
              r_min_break <= cand_break_i;
              r_min_idx   <= r_count[IDX_BITS-1:0];
            end
            if (w_final) begin
              r_state <= DECIDE;
            end
          end
        end
        DECIDE: begin
          r_sel_var    <= w_rd_var;
          r_sel_break  <= w_rd_break;
          r_sel_greedy <= !w_noise;
          r_state      <= OUTPUT;
        end
        OUTPUT: begin
          if (sel_ready_i) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign cand_ready_o = (r_state == COLLECT);
  assign sel_valid_o  = (r_state == OUTPUT);
  assign busy_o       = (r_state != IDLE);
  assign sel_var_o    = r_sel_var;
  assign sel_break_o  = r_sel_break;
  assign sel_greedy_o = r_sel_greedy;

endmodule

`default_nettype wire

// File: doc/flip_candidate_selector.md
# flip_candidate_selector

Sequential WalkSAT pick stage directly downstream of the break-value counter. For one unsatisfied clause, it accepts up to NUM_LITERALS candidate variables, each with its break value, through a valid/ready stream. It then chooses the variable to flip: a zero-break freebie if one exists, otherwise a noise-driven random pick or the greedy minimum-break pick. The result goes to the flip/assignment-update stage through a second valid/ready handshake.

## Interface
- NUM_LITERALS, 3: maximum candidates per clause (2..8)
- NUM_CLAUSES_BITS, 5: break-value width, matches break-counter output
- VAR_BITS, 8: variable index width
- RAND_BITS, 8: random word / noise threshold width
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- abort_i  in  1  synchronous return to IDLE from any state
- start_i  in  1  begin a new clause; accepted only in IDLE
- noise_thresh_i  in  RAND_BITS  noise probability p scaled to 2^RAND_BITS; sampled at start
- rand_i  in  RAND_BITS  LFSR word from the random source
- cand_valid_i  in  1  candidate beat valid
- cand_ready_o  out  1  stage accepts a beat
- cand_var_i  in  VAR_BITS  candidate variable index
- cand_break_i  in  NUM_CLAUSES_BITS  break value of candidate
- cand_last_i  in  1  final candidate of this clause
- sel_valid_o  out  1  selection available
- sel_ready_i  in  1  downstream accepts selection
- sel_var_o  out  VAR_BITS  chosen variable
- sel_break_o  out  NUM_CLAUSES_BITS  break value of chosen variable
- sel_greedy_o  out  1  1 = greedy/freebie pick, 0 = noise pick
- busy_o  out  1  state != IDLE

## Operation
- States: IDLE, COLLECT, DECIDE, OUTPUT.
- IDLE:
  - start_i=1 → COLLECT.
  - Sample noise_thresh_i and rand_i into rand_a.
  - Clear count, min_break and min_idx.
- COLLECT:
  - cand_ready_o=1.
  - Each handshake (valid & ready) stores {var, break} at slot count and increments count.
  - If break < min_break, or on the first beat, update min_break/min_idx. The comparison is strict, so the lowest slot wins ties.
  - Go to DECIDE on a beat with cand_last_i=1, or on the NUM_LITERALS-th beat regardless of cand_last_i.
- DECIDE (exactly 1 cycle):
  - rand_b = rand_i sampled this cycle.
  - noise = (rand_a < thresh) && (min_break != 0).
  - noise=1: idx = rand_b mod count (combinational modulo, count ≤ 8), sel_greedy_o=0.
  - noise=0: idx = min_idx, sel_greedy_o=1.
  - Register the outputs from slot idx, then go to OUTPUT.
- OUTPUT:
  - sel_valid_o=1.
  - sel_var_o, sel_break_o and sel_greedy_o are held stable until sel_ready_i=1, then go to IDLE.
- Ignored inputs:
  - start_i outside IDLE.
  - cand_valid_i outside COLLECT (cand_ready_o=0 there).
- abort_i has priority over every transition: next state IDLE, pending selection discarded.
- Break values are unsigned, compared at full width, with no saturation.

## Timing
- Reset values: cand_ready_o=0, sel_valid_o=0, sel_var_o=0, sel_break_o=0, sel_greedy_o=0, busy_o=0; state IDLE.
- Reset asserted mid-operation clears everything immediately (asynchronous); on deassertion the block is in IDLE.
- start_i sampled at edge T → cand_ready_o=1 from T+1.
- One candidate per cycle at full throughput.
- Last beat accepted at edge L → DECIDE during cycle L+1 → sel_valid_o=1 from L+2.
- Minimum clause latency (start to sel_valid) is NUM_LITERALS+2 cycles with back-to-back beats.
- Selection accepted at edge E → IDLE at E+1. start_i is accepted at E+1 at the earliest, so one idle cycle separates clauses.
- abort_i at edge A → all outputs at their reset values from A+1.

## Structure
- Shared package (sat_pkg):
  - state enum {IDLE, COLLECT, DECIDE, OUTPUT}
  - CAND_IDX_BITS = clog2(NUM_LITERALS)
  - candidate struct {var, break}
- Sub-module candidate_buffer:
  - Register array of NUM_LITERALS slots with write port (slot, var, break) and combinational read by idx.
  - Clear on reset/abort.
  - The top level keeps the FSM, running minimum and noise decision.

## Test plan
- Greedy pick:
  - Stimulus: thresh=0; beats (var,break) (10,2),(11,1),(12,3), last on beat 3, back-to-back.
  - Required: sel_var=11, sel_break=1, greedy=1; sel_valid exactly 2 cycles after the last beat.
- Freebie beats noise:
  - Stimulus: thresh=255, rand_a=0; breaks (20,0),(21,4),(22,4).
  - Required: sel_var=20, break=0, greedy=1.
- Noise pick:
  - Stimulus: thresh=128, rand_a=10, rand_b=5; breaks (10,2),(11,2),(12,3).
  - Required: idx=5 mod 3=2 → sel_var=12, break=3, greedy=0.
- Ties:
  - Stimulus: thresh=0; breaks all 1 for vars 30,31,32.
  - Required: sel_var=30.
- Short clause and backpressure:
  - Stimulus: last on beat 2 with (40,3),(41,2); sel_ready_i low for 5 cycles; start_i pulsed during OUTPUT.
  - Required: sel_var=41, outputs stable throughout, the start pulse ignored; IDLE one cycle after accept.
- Reset and abort:
  - Stimulus: reset low mid-COLLECT; separately, abort_i in OUTPUT.
  - Required for reset: all outputs 0 immediately.
  - Required for abort: sel_valid_o=0 the next cycle; busy_o=0; a new clause runs correctly afterwards.
